load_store_buffer: RTL and testbench

- Consumer end of the address-unit interface: captures {addr, op, rob_number, ls_value} from the AU into an in-order FIFO.
- Issues each entry to the data-memory port one at a time, using a req/ready handshake.
- Broadcasts load results and store completions on the CDB toward the ROB.
- Sits between the AU and the data cache/memory controller.

---
 rtl/lsb_pkg.sv | 38 +++
 rtl/lsb_lane_align.sv | 61 ++++++
 rtl/load_store_buffer.sv | 238 +++++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_pkg.sv
// Load/store buffer shared types: memory opcode encodings, FSM states and the queued entry.
// Tag 0 is reserved as "no entry" throughout.
package lsb_pkg;

  localparam int unsigned LSB_ROB_W = 3;

  localparam logic [4:0] OP_LB  = 5'd11;
  localparam logic [4:0] OP_LH  = 5'd12;
  localparam logic [4:0] OP_LW  = 5'd13;
  localparam logic [4:0] OP_LBU = 5'd14;
  localparam logic [4:0] OP_LHU = 5'd15;
  localparam logic [4:0] OP_SB  = 5'd16;
  localparam logic [4:0] OP_SH  = 5'd17;
  localparam logic [4:0] OP_SW  = 5'd18;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_COMMIT,
    MEM,
    DRAIN
  } lsb_state_e;

  typedef struct packed {
    logic [31:0]          addr;
    logic [4:0]           op;
    logic [LSB_ROB_W-1:0] rob;
    logic [31:0]          value;
  } lsb_entry_t;

  function automatic logic is_load(input logic [4:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/lsb_lane_align.sv
// Combinational byte-lane handling: store strobe/data replication and load extract/extend.
// LSB_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses raise misalign_o; otherwise it is 0.
module lsb_lane_align
  import lsb_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_value_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_value_o,
  output logic        misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word_i[{lane_i, 3'b000} +: 8];
  // Halfword lane uses addr[1] only, so addr[0] is implicitly masked.
  assign ld_half = lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    wstrb_o    = '0;
    wdata_o    = '0;
    ld_value_o = '0;
    case (op_i)
      OP_LB:  ld_value_o = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_value_o = {24'b0, ld_byte};
      OP_LH:  ld_value_o = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_value_o = {16'b0, ld_half};
      OP_LW:  ld_value_o = ld_word_i;
      OP_SB: begin
        wstrb_o = 4'b0001 << lane_i;
        wdata_o = {4{st_value_i[7:0]}};
      end
      OP_SH: begin
        wstrb_o = 4'b0011 << {lane_i[1], 1'b0};
        wdata_o = {2{st_value_i[15:0]}};
      end
      OP_SW: begin
        wstrb_o = 4'b1111;
        wdata_o = st_value_i;
      end
      default: ;
    endcase
  end

`ifdef LSB_MISALIGN_TRAP_EN
  always_comb begin
    case (op_i)
      OP_LH, OP_LHU, OP_SH: misalign_o = lane_i[0];
      OP_LW, OP_SW:         misalign_o = |lane_i;
      default:              misalign_o = 1'b0;
    endcase
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer between the AU and data memory; loads issue 1 cycle after enqueue, CDB 1 cycle after mem_ready.
// Stores wait for ROB commit; lsb_full stalls issue; LSB_MISALIGN_TRAP_EN enables misaligned-access traps.
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = LSB_ROB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             au_valid,
  input  logic [31:0]      addr,
  input  logic [4:0]       op,
  input  logic [ROB_W-1:0] rob_number,
  input  logic [31:0]      ls_value,
  output logic             lsb_full,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [31:0]      cdb_value,
  output logic             cdb_exc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  lsb_entry_t fifo_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  lsb_state_e       state_q, state_d;

  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic             cdb_valid_q, cdb_valid_d, cdb_exc_q, cdb_exc_d;
  logic [ROB_W-1:0] cdb_rob_q, cdb_rob_d;
  logic [31:0]      cdb_value_q, cdb_value_d;

  lsb_entry_t       head_e;
  logic [ROB_W-1:0] head_rob;
  logic             head_store, head_known;
  logic             push, pop, issue, clear, keep_head;
  logic [3:0]       al_wstrb;
  logic [31:0]      al_wdata, al_ld_value;
  logic             misalign;

  assign head_e     = fifo_mem[head_q];
  assign head_rob   = ROB_W'(head_e.rob);
  assign head_store = is_store(head_e.op);
  assign head_known = head_store || is_load(head_e.op);
  assign lsb_full   = (count_q == CNT_W'(DEPTH));
  assign push       = au_valid && (rob_number != '0) && !lsb_full && !flush;

  lsb_lane_align u_align (
    .op_i       (head_e.op),
    .lane_i     (head_e.addr[1:0]),
    .st_value_i (head_e.value),
    .ld_word_i  (mem_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .ld_value_o (al_ld_value),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_q] <= '{addr: addr, op: op, rob: LSB_ROB_W'(rob_number), value: ls_value};
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    cdb_valid_d = 1'b0;
    cdb_rob_d   = '0;
    cdb_value_d = '0;
    cdb_exc_d   = 1'b0;
    issue       = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    keep_head   = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          clear = 1'b1;
        end else if (count_q != '0) begin
          if (!head_known) begin
            pop         = 1'b1;
            cdb_valid_d = 1'b1;
            cdb_rob_d   = head_rob;
          end else if (head_store) begin
            state_d = WAIT_COMMIT;
          end else if (misalign) begin
            pop         = 1'b1;
            cdb_valid_d = 1'b1;
            cdb_rob_d   = head_rob;
            cdb_value_d = head_e.addr;
            cdb_exc_d   = 1'b1;
          end else begin
            issue = 1'b1;
          end
        end
      end
      WAIT_COMMIT: begin
        if (flush) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (commit_valid && (commit_rob == head_rob)) begin
          if (misalign) begin
            pop         = 1'b1;
            cdb_valid_d = 1'b1;
            cdb_rob_d   = head_rob;
            cdb_value_d = head_e.addr;
            cdb_exc_d   = 1'b1;
            state_d     = IDLE;
          end else begin
            issue = 1'b1;
          end
        end
      end
      MEM: begin
        // A flushed load still owns the memory port until its handshake completes.
        if (flush && !mem_we_q) begin
          clear = 1'b1;
          if (mem_ready) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          keep_head = flush;
          if (mem_ready) begin
            mem_req_d   = 1'b0;
            pop         = 1'b1;
            state_d     = IDLE;
            cdb_valid_d = 1'b1;
            cdb_rob_d   = head_rob;
            cdb_value_d = mem_we_q ? 32'h0 : al_ld_value;
          end
        end
      end
      DRAIN: begin
        clear = flush;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      mem_req_d   = 1'b1;
      mem_we_d    = head_store;
      mem_addr_d  = {head_e.addr[31:2], 2'b00};
      mem_wdata_d = al_wdata;
      mem_wstrb_d = al_wstrb;
      state_d     = MEM;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (keep_head) begin
      // Flush behind a committed in-flight store: keep only the store itself.
      head_d  = pop ? head_q + PTR_W'(1) : head_q;
      tail_d  = head_q + PTR_W'(1);
      count_d = pop ? CNT_W'(0) : CNT_W'(1);
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_value_q <= '0;
      cdb_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_value_q <= cdb_value_d;
      cdb_exc_q   <= cdb_exc_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign cdb_valid = cdb_valid_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_value = cdb_value_q;
  assign cdb_exc   = cdb_exc_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: vector table for single-entry lane cases plus
// hand-written sequences for latency, full, flush and commit ordering.
module tb_load_store_buffer;
  import lsb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        au_valid;
  logic [31:0] addr;
  logic [4:0]  op;
  logic [2:0]  rob_number;
  logic [31:0] ls_value;
  logic        lsb_full;
  logic        commit_valid;
  logic [2:0]  commit_rob;
  logic        flush;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        cdb_valid;
  logic [2:0]  cdb_rob;
  logic [31:0] cdb_value;
  logic        cdb_exc;
  logic        mem_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: accepts/completes in the same cycle whenever enabled.
  assign mem_ready = mem_req & mem_en;

  load_store_buffer #(.DEPTH(4), .ROB_W(3)) dut (
    .clk(clk), .rst(rst), .au_valid(au_valid), .addr(addr), .op(op),
    .rob_number(rob_number), .ls_value(ls_value), .lsb_full(lsb_full),
    .commit_valid(commit_valid), .commit_rob(commit_rob), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value), .cdb_exc(cdb_exc)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] rdata;
    logic [2:0]  rob;
    bit          store;
    bit          issue;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_value;
    bit          e_exc;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic [4:0] o, input logic [31:0] a, input logic [31:0] v,
                              input logic [31:0] rd, input logic [2:0] r, input bit st,
                              input bit iss, input logic [31:0] ea, input logic [31:0] ewd,
                              input logic [3:0] ews, input logic [31:0] ev, input bit ex);
    vec_t t;
    t.op = o; t.addr = a; t.val = v; t.rdata = rd; t.rob = r; t.store = st; t.issue = iss;
    t.e_addr = ea; t.e_wdata = ewd; t.e_wstrb = ews; t.e_value = ev; t.e_exc = ex;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enq(input logic [4:0] o, input logic [31:0] a, input logic [31:0] v,
                     input logic [2:0] r);
    au_valid = 1'b1; op = o; addr = a; ls_value = v; rob_number = r;
    tick();
    au_valid = 1'b0;
  endtask

  task automatic wait_cdb(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (cdb_valid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic count_activity(input int cycles, output int n_req, output int n_cdb);
    n_req = 0;
    n_cdb = 0;
    for (int i = 0; i < cycles; i++) begin
      if (mem_req)   n_req++;
      if (cdb_valid) n_cdb++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen, saw_req, saw_cdb;
    int          n_req, n_cdb;
    logic [31:0] g_addr, g_wdata, g_value;
    logic [3:0]  g_wstrb;
    logic [2:0]  g_rob;
    logic        g_we, g_exc;
    logic [2:0]  got_robs[$];

    vt[0]  = mk(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 3'd3, 0, 1, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);
    vt[1]  = mk(OP_LB,  32'h103, 32'h0, 32'h80112233, 3'd2, 0, 1, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80, 0);
    vt[2]  = mk(OP_LBU, 32'h103, 32'h0, 32'h80112233, 3'd4, 0, 1, 32'h100, 32'h0, 4'h0, 32'h00000080, 0);
    vt[3]  = mk(OP_LH,  32'h102, 32'h0, 32'h80011234, 3'd1, 0, 1, 32'h100, 32'h0, 4'h0, 32'hFFFF8001, 0);
    vt[4]  = mk(OP_LHU, 32'h100, 32'h0, 32'h8001F234, 3'd6, 0, 1, 32'h100, 32'h0, 4'h0, 32'h0000F234, 0);
    vt[5]  = mk(OP_LB,  32'h101, 32'h0, 32'h11227F44, 3'd7, 0, 1, 32'h100, 32'h0, 4'h0, 32'h0000007F, 0);
    vt[6]  = mk(OP_SH,  32'h202, 32'h00001234, 32'h0, 3'd5, 1, 1, 32'h200, 32'h12341234, 4'hC, 32'h0, 0);
    vt[7]  = mk(OP_SB,  32'h301, 32'hFFFFFFAB, 32'h0, 3'd6, 1, 1, 32'h300, 32'hABABABAB, 4'h2, 32'h0, 0);
    vt[8]  = mk(OP_SW,  32'h400, 32'hCAFEF00D, 32'h0, 3'd7, 1, 1, 32'h400, 32'hCAFEF00D, 4'hF, 32'h0, 0);
    vt[9]  = mk(5'd3,   32'h500, 32'h0, 32'h0, 3'd4, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0);
`ifdef LSB_MISALIGN_TRAP_EN
    vt[10] = mk(OP_LW,  32'h101, 32'h0, 32'h11223344, 3'd1, 0, 0, 32'h0, 32'h0, 4'h0, 32'h101, 1);
    vt[11] = mk(OP_LH,  32'h103, 32'h0, 32'hABCD0000, 3'd2, 0, 0, 32'h0, 32'h0, 4'h0, 32'h103, 1);
    vt[12] = mk(OP_SW,  32'h402, 32'h55AA55AA, 32'h0, 3'd3, 1, 0, 32'h0, 32'h0, 4'h0, 32'h402, 1);
`else
    vt[10] = mk(OP_LW,  32'h101, 32'h0, 32'h11223344, 3'd1, 0, 1, 32'h100, 32'h0, 4'h0, 32'h11223344, 0);
    vt[11] = mk(OP_LH,  32'h103, 32'h0, 32'hABCD0000, 3'd2, 0, 1, 32'h100, 32'h0, 4'h0, 32'hFFFFABCD, 0);
    vt[12] = mk(OP_SW,  32'h402, 32'h55AA55AA, 32'h0, 3'd3, 1, 1, 32'h400, 32'h55AA55AA, 4'hF, 32'h0, 0);
`endif

    rst = 1'b0; au_valid = 1'b0; addr = '0; op = '0; rob_number = '0; ls_value = '0;
    commit_valid = 1'b0; commit_rob = '0; flush = 1'b0; mem_rdata = '0; mem_en = 1'b0;
    tick(); tick();
    check("rst_mem_req", mem_req, 0);
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_lsb_full", lsb_full, 0);
    check("rst_cdb_exc", cdb_exc, 0);
    rst = 1'b1;
    tick();

    // Zero-wait load latency: mem_req 1 cycle, cdb 2 cycles after the enqueue edge.
    mem_en = 1'b1; mem_rdata = 32'hDEADBEEF;
    enq(OP_LW, 32'h100, 32'h0, 3'd3);
    check("lat_req_early", mem_req, 0);
    tick();
    check("lat_req", mem_req, 1);
    check("lat_addr", mem_addr, 32'h100);
    tick();
    check("lat_cdb_valid", cdb_valid, 1);
    check("lat_cdb_rob", cdb_rob, 3);
    check("lat_cdb_value", cdb_value, 32'hDEADBEEF);
    tick();

    foreach (vt[i]) begin
      mem_rdata = vt[i].rdata;
      enq(vt[i].op, vt[i].addr, vt[i].val, vt[i].rob);
      if (vt[i].store) begin
        tick(); tick();
        check($sformatf("v%0d_nospec_req", i), mem_req, 0);
        commit_valid = 1'b1; commit_rob = vt[i].rob;
        tick();
        commit_valid = 1'b0;
      end
      saw_req = 1'b0; saw_cdb = 1'b0;
      g_addr = '0; g_wdata = '0; g_wstrb = '0; g_we = 1'b0;
      g_rob = '0; g_value = '0; g_exc = 1'b0;
      for (int c = 0; c < 8 && !saw_cdb; c++) begin
        if (mem_req && !saw_req) begin
          saw_req = 1'b1;
          g_addr = mem_addr; g_we = mem_we; g_wstrb = mem_wstrb; g_wdata = mem_wdata;
        end
        if (cdb_valid) begin
          saw_cdb = 1'b1;
          g_rob = cdb_rob; g_value = cdb_value; g_exc = cdb_exc;
        end else begin
          tick();
        end
      end
      tick();
      check($sformatf("v%0d_cdb_seen", i), saw_cdb, 1);
      check($sformatf("v%0d_issued", i), saw_req, vt[i].issue);
      check($sformatf("v%0d_cdb_rob", i), g_rob, vt[i].rob);
      check($sformatf("v%0d_cdb_value", i), g_value, vt[i].e_value);
      check($sformatf("v%0d_cdb_exc", i), g_exc, vt[i].e_exc);
      if (saw_req && vt[i].issue) begin
        check($sformatf("v%0d_mem_addr", i), g_addr, vt[i].e_addr);
        check($sformatf("v%0d_mem_we", i), g_we, vt[i].store);
        if (vt[i].store) begin
          check($sformatf("v%0d_wstrb", i), g_wstrb, vt[i].e_wstrb);
          check($sformatf("v%0d_wdata", i), g_wdata, vt[i].e_wdata);
        end
      end
    end

    // Tag 0 is never enqueued.
    enq(OP_LW, 32'h100, 32'h0, 3'd0);
    count_activity(5, n_req, n_cdb);
    check("rob0_no_req", n_req, 0);
    check("rob0_no_cdb", n_cdb, 0);

    // Fill with memory stalled; a fifth enqueue must be dropped.
    mem_en = 1'b0; mem_rdata = 32'h00000042;
    for (int r = 1; r <= 4; r++) enq(OP_LW, 32'h1000 + 32'(r * 4), 32'h0, 3'(r));
    check("full_after4", lsb_full, 1);
    enq(OP_LW, 32'h2000, 32'h0, 3'd5);
    check("full_after5", lsb_full, 1);
    mem_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (cdb_valid) got_robs.push_back(cdb_rob);
      tick();
    end
    check("full_pulses", got_robs.size(), 4);
    for (int k = 0; k < got_robs.size() && k < 4; k++)
      check($sformatf("full_order%0d", k), got_robs[k], k + 1);
    check("full_cleared", lsb_full, 0);

    // Flush with a load outstanding: drain the handshake, no cdb pulse.
    mem_en = 1'b0;
    enq(OP_LW, 32'h600, 32'h0, 3'd2);
    tick();
    check("fl_ld_req", mem_req, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    check("fl_drain_hold", mem_req, 1);
    mem_en = 1'b1;
    count_activity(6, n_req, n_cdb);
    check("fl_ld_no_cdb", n_cdb, 0);
    check("fl_ld_req_drop", mem_req, 0);
    mem_rdata = 32'h00000077;
    enq(OP_LW, 32'h700, 32'h0, 3'd3);
    wait_cdb(8, seen);
    check("fl_next_seen", seen, 1);
    check("fl_next_rob", cdb_rob, 3);
    check("fl_next_value", cdb_value, 32'h77);
    tick();

    // Flush while a store awaits commit: the store is discarded.
    enq(OP_SW, 32'h800, 32'h1, 3'd6);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; commit_valid = 1'b1; commit_rob = 3'd6;
    tick();
    commit_valid = 1'b0;
    count_activity(5, n_req, n_cdb);
    check("fl_wc_no_req", n_req, 0);
    check("fl_wc_no_cdb", n_cdb, 0);

    // Flush behind a committed in-flight store: store completes, younger load is dropped.
    mem_en = 1'b0;
    enq(OP_SW, 32'h900, 32'h12345678, 3'd7);
    enq(OP_LW, 32'h904, 32'h0, 3'd1);
    commit_valid = 1'b1; commit_rob = 3'd7;
    tick();
    commit_valid = 1'b0;
    check("fl_st_req", mem_req, 1);
    check("fl_st_we", mem_we, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; mem_en = 1'b1;
    wait_cdb(6, seen);
    check("fl_st_cdb_seen", seen, 1);
    check("fl_st_cdb_rob", cdb_rob, 7);
    check("fl_st_cdb_value", cdb_value, 0);
    tick();
    count_activity(6, n_req, n_cdb);
    check("fl_st_no_load", n_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
